// File: rtl/decode_mmucheck_mc.sv
// Multi-channel MMU permission check with a shared fault queue.
// Latency: per-channel results 1 cycle after acceptance; faults reach the queue 1 cycle after that.
// Backpressure: oBUSY stalls all channels when the queue cannot absorb P_CH more faults.
//
// Ports:
//   iCLOCK, iRESET_SYNC (sync, active-high), iFLUSH      - clock, reset, pipeline/queue discard
//   iPAGING_ENA, iVALID, iKERNEL_ACCESS, iWRITE_CHECK,
//   iMMU_FLAGS (14 bits per channel)                      - check requests
//   oBUSY                                                 - request stall
//   oVALID, oIRQ40/41/42                                  - registered per-channel results
//   oFAULT_VALID/CH/CODE, iFAULT_ACK, oFAULT_COUNT        - fault queue head, pop, occupancy
//   oFAULT_OVF, iOVF_CLEAR                                - sticky overflow flag and its clear
module decode_mmucheck_mc #(
  parameter int P_CH    = 2,
  parameter int P_DEPTH = 4
) (
  input  logic                iCLOCK,
  input  logic                iRESET_SYNC,
  input  logic                iFLUSH,
  input  logic                iPAGING_ENA,
  input  logic [P_CH-1:0]     iVALID,
  output logic                oBUSY,
  input  logic [P_CH-1:0]     iKERNEL_ACCESS,
  input  logic [P_CH-1:0]     iWRITE_CHECK,
  input  logic [14*P_CH-1:0]  iMMU_FLAGS,
  output logic [P_CH-1:0]     oVALID,
  output logic [P_CH-1:0]     oIRQ40,
  output logic [P_CH-1:0]     oIRQ41,
  output logic [P_CH-1:0]     oIRQ42,
  output logic                oFAULT_VALID,
  output logic [1:0]          oFAULT_CH,
  output logic [2:0]          oFAULT_CODE,
  input  logic                iFAULT_ACK,
  output logic [4:0]          oFAULT_COUNT,
  output logic                oFAULT_OVF,
  input  logic                iOVF_CLEAR
);

  localparam int AW = $clog2(P_DEPTH);

  // stage register: code is one-hot {IRQ42, IRQ41, IRQ40} or zero
  logic [P_CH-1:0] stg_vld;
  logic [2:0]      stg_code [P_CH];

  // fault queue
  logic [1:0]    q_ch   [P_DEPTH];
  logic [2:0]    q_code [P_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic          ovf;

  logic            busy;
  logic [P_CH-1:0] acc;
  logic [2:0]      cls [P_CH];
  logic [5:0]      pending, space, npush;
  logic [P_CH-1:0] push_en;
  logic [AW-1:0]   push_idx [P_CH];
  logic            drop, pop;

  // only bits 0, 2, 3, 4 and 5 of each channel's flags are interpreted
  logic unused_flags;
  assign unused_flags = ^iMMU_FLAGS;

  // classification of the incoming request, first matching rule wins
  always_comb begin
    for (int n = 0; n < P_CH; n++) begin
      acc[n] = iVALID[n] & ~busy & ~iFLUSH & ~iRESET_SYNC;
      cls[n] = 3'b000;
      if (iPAGING_ENA) begin
        if (!iMMU_FLAGS[14*n])
          cls[n] = 3'b001;
        else if (!iMMU_FLAGS[14*n+3])
          cls[n] = 3'b100;
        else if (!iKERNEL_ACCESS[n] && iMMU_FLAGS[14*n+4 +: 2] == 2'b00)
          cls[n] = 3'b010;
        else if (iWRITE_CHECK[n] && !iMMU_FLAGS[14*n+2])
          cls[n] = 3'b010;
      end
    end
  end

  // push slot allocation: faulting stage channels take consecutive slots in
  // ascending channel order; a pop in the same cycle frees one slot
  always_comb begin
    pop     = iFAULT_ACK && (count != 5'd0);
    space   = 6'(P_DEPTH) - {1'b0, count} + {5'b0, pop};
    pending = '0;
    npush   = '0;
    drop    = 1'b0;
    for (int n = 0; n < P_CH; n++) begin
      push_en[n]  = 1'b0;
      push_idx[n] = wr_ptr + npush[AW-1:0];
      if (stg_code[n] != 3'b000) begin
        pending = pending + 6'd1;
        if (npush < space) begin
          push_en[n] = 1'b1;
          npush      = npush + 6'd1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  // stall unless the queue has room for the pending faults plus a full new set
  assign busy = ({1'b0, count} + pending + 6'(P_CH)) > 6'(P_DEPTH);

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      stg_vld <= '0;
      for (int n = 0; n < P_CH; n++) stg_code[n] <= 3'b000;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else if (iFLUSH) begin
      stg_vld <= '0;
      for (int n = 0; n < P_CH; n++) stg_code[n] <= 3'b000;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      stg_vld <= acc;
      for (int n = 0; n < P_CH; n++) stg_code[n] <= acc[n] ? cls[n] : 3'b000;
      wr_ptr  <= wr_ptr + npush[AW-1:0];
      rd_ptr  <= rd_ptr + AW'(pop);
      count   <= count + npush[4:0] - {4'b0, pop};
      if (drop)
        ovf <= 1'b1;
      else if (iOVF_CLEAR)
        ovf <= 1'b0;
    end
  end

  // queue storage needs no reset: head outputs are masked by the count
  always_ff @(posedge iCLOCK) begin
    if (!iRESET_SYNC && !iFLUSH) begin
      for (int n = 0; n < P_CH; n++) begin
        if (push_en[n]) begin
          q_ch[push_idx[n]]   <= 2'(n);
          q_code[push_idx[n]] <= stg_code[n];
        end
      end
    end
  end

  always_comb begin
    for (int n = 0; n < P_CH; n++) begin
      oIRQ40[n] = stg_code[n][0];
      oIRQ41[n] = stg_code[n][1];
      oIRQ42[n] = stg_code[n][2];
    end
  end

  assign oVALID       = stg_vld;
  assign oBUSY        = busy;
  assign oFAULT_VALID = (count != 5'd0);
  assign oFAULT_CH    = oFAULT_VALID ? q_ch[rd_ptr]   : 2'b00;
  assign oFAULT_CODE  = oFAULT_VALID ? q_code[rd_ptr] : 3'b000;
  assign oFAULT_COUNT = count;
  assign oFAULT_OVF   = ovf;

endmodule

// File: tb/tb_decode_mmucheck_mc.sv
// Bench for decode_mmucheck_mc (P_CH=2, P_DEPTH=4): directed vectors, scoreboard queues.
// Results are checked by a negedge monitor against queued expectations.
// Queue-head entries are checked when the bench acknowledges them.
module tb_decode_mmucheck_mc;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, paging, busy, fault_valid, ack, ovf, ovf_clr;
  logic [1:0]  vld, kern, wr, ovld, irq40, irq41, irq42, fault_ch;
  logic [27:0] flags;
  logic [2:0]  fault_code;
  logic [4:0]  fault_count;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] res_q[$];
  logic [4:0] flt_q[$];

  decode_mmucheck_mc #(.P_CH(2), .P_DEPTH(4)) dut (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(flush), .iPAGING_ENA(paging),
    .iVALID(vld), .oBUSY(busy), .iKERNEL_ACCESS(kern), .iWRITE_CHECK(wr),
    .iMMU_FLAGS(flags), .oVALID(ovld), .oIRQ40(irq40), .oIRQ41(irq41), .oIRQ42(irq42),
    .oFAULT_VALID(fault_valid), .oFAULT_CH(fault_ch), .oFAULT_CODE(fault_code),
    .iFAULT_ACK(ack), .oFAULT_COUNT(fault_count), .oFAULT_OVF(ovf), .iOVF_CLEAR(ovf_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // e0/e1 are one-hot {IRQ42, IRQ41, IRQ40} for channel 0/1
  task automatic expect_res(input logic [1:0] v, input logic [2:0] e0, input logic [2:0] e1,
                            input bit push_flt);
    res_q.push_back({v, e1[0], e0[0], e1[1], e0[1], e1[2], e0[2]});
    if (push_flt) begin
      if (v[0] && e0 != 3'b000) flt_q.push_back({2'd0, e0});
      if (v[1] && e1 != 3'b000) flt_q.push_back({2'd1, e1});
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] k, input logic [1:0] w,
                       input logic [13:0] f0, input logic [13:0] f1, input logic pg);
    vld = v; kern = k; wr = w; flags = {f1, f0}; paging = pg;
  endtask

  task automatic issue(input logic [1:0] v, input logic [1:0] k, input logic [1:0] w,
                       input logic [13:0] f0, input logic [13:0] f1, input logic pg,
                       input logic [2:0] e0, input logic [2:0] e1);
    expect_res(v, e0, e1, 1'b1);
    drive(v, k, w, f0, f1, pg);
    step();
    vld = 2'b00;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      ack = 1'b1;
      step();
    end
    ack = 1'b0;
  endtask

  // monitor
  always @(negedge clk) begin
    if ((|ovld) === 1'b1) begin
      if (res_q.size() == 0) begin
        n_chk++;
        $display("FAIL result_unexpected: got %b expected none", {ovld, irq40, irq41, irq42});
      end else begin
        chk("result", {ovld, irq40, irq41, irq42}, res_q.pop_front());
      end
    end
    if (ack === 1'b1 && flush === 1'b0 && fault_valid === 1'b1) begin
      if (flt_q.size() == 0) begin
        n_chk++;
        $display("FAIL fault_unexpected: got %0h expected none", {fault_ch, fault_code});
      end else begin
        chk("fault_head", {fault_ch, fault_code}, flt_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ack = 1'b0; ovf_clr = 1'b0;
    drive(2'b11, 2'b00, 2'b00, 14'h0, 14'h0, 1'b1);
    // reset state, requests ignored while in reset
    step(); step();
    chk("rst_valid", ovld, 0);
    chk("rst_irq", {irq40, irq41, irq42}, 0);
    chk("rst_fault_head", {fault_valid, fault_ch, fault_code}, 0);
    chk("rst_count", fault_count, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0; vld = 2'b00;
    chk("rst_busy", busy, 0);

    // basic: ch0 not present, ch1 user with full permissions
    issue(2'b11, 2'b00, 2'b00, 14'h0000, 14'h0039, 1'b1, 3'b001, 3'b000);
    chk("basic_valid", ovld, 2'b11);
    step();
    chk("basic_head", {fault_valid, fault_ch, fault_code}, {1'b1, 2'd0, 3'b001});
    chk("basic_count", fault_count, 1);
    drain(1);
    chk("basic_drained", fault_count, 0);

    // privilege, write-protect and invalid-instruction classes
    issue(2'b11, 2'b10, 2'b00, 14'h0009, 14'h0009, 1'b1, 3'b010, 3'b000);
    issue(2'b11, 2'b11, 2'b11, 14'h0019, 14'h001D, 1'b1, 3'b010, 3'b000);
    issue(2'b11, 2'b00, 2'b00, 14'h0001, 14'h0008, 1'b1, 3'b100, 3'b001);
    step();
    chk("class_count", fault_count, 4);
    chk("class_busy", busy, 1);
    drain(4);
    chk("class_drained", fault_count, 0);

    // paging disabled: nothing faults
    issue(2'b11, 2'b00, 2'b00, 14'h0000, 14'h0000, 1'b0, 3'b000, 3'b000);
    step();
    chk("nopaging_count", fault_count, 0);

    // backpressure with continuous faulting requests
    expect_res(2'b11, 3'b001, 3'b001, 1'b1);
    expect_res(2'b11, 3'b001, 3'b001, 1'b1);
    drive(2'b11, 2'b00, 2'b00, 14'h0, 14'h0, 1'b1);
    chk("bp_busy0", busy, 0);
    step();
    chk("bp_busy1", busy, 0);
    step();
    chk("bp_busy2", busy, 1);
    chk("bp_count2", fault_count, 2);
    step();
    chk("bp_count3", fault_count, 4);
    chk("bp_busy3", busy, 1);
    step();
    chk("bp_count4", fault_count, 4);
    chk("bp_ovf", ovf, 0);
    vld = 2'b00;
    drain(4);
    chk("bp_drained", fault_count, 0);
    chk("bp_busy_end", busy, 0);

    // overflow with the stall overridden
    force dut.busy = 1'b0;
    expect_res(2'b11, 3'b001, 3'b001, 1'b1);
    expect_res(2'b11, 3'b001, 3'b001, 1'b1);
    expect_res(2'b11, 3'b001, 3'b001, 1'b0);
    drive(2'b11, 2'b00, 2'b00, 14'h0, 14'h0, 1'b1);
    step(); step(); step();
    vld = 2'b00;
    step();
    chk("ovf_set", ovf, 1);
    chk("ovf_count", fault_count, 4);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 0);
    expect_res(2'b11, 3'b001, 3'b001, 1'b0);
    drive(2'b11, 2'b00, 2'b00, 14'h0, 14'h0, 1'b1);
    step();
    vld = 2'b00; ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf, 1);
    chk("ovf_count_kept", fault_count, 4);
    release dut.busy;
    #1;
    chk("ovf_busy", busy, 1);
    drain(4);
    chk("ovf_drained", fault_count, 0);

    // flush with queued faults, concurrent ack and new requests
    issue(2'b11, 2'b00, 2'b00, 14'h0, 14'h0, 1'b1, 3'b001, 3'b001);
    issue(2'b01, 2'b00, 2'b00, 14'h0, 14'h0, 1'b1, 3'b001, 3'b000);
    step();
    chk("flush_pre_count", fault_count, 3);
    flush = 1'b1; ack = 1'b1;
    drive(2'b11, 2'b00, 2'b00, 14'h0, 14'h0, 1'b1);
    step();
    flush = 1'b0; ack = 1'b0; vld = 2'b00;
    flt_q.delete();
    chk("flush_count", fault_count, 0);
    chk("flush_valid", ovld, 0);
    chk("flush_head", fault_valid, 0);
    chk("flush_ovf_kept", ovf, 1);
    step();
    chk("flush_no_result", ovld, 0);

    // reset with a result in flight
    expect_res(2'b11, 3'b001, 3'b001, 1'b0);
    drive(2'b11, 2'b00, 2'b00, 14'h0, 14'h0, 1'b1);
    step();
    vld = 2'b00; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_count", fault_count, 0);
    chk("midrst_valid", ovld, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_busy", busy, 0);
    step();
    chk("midrst_no_push", fault_count, 0);

    chk("res_q_empty", res_q.size(), 0);
    chk("flt_q_empty", flt_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/decode_mmucheck_mc.md
DECODE_MMUCHECK_MC -- requirements
Module: decode_mmucheck_mc

Interface
REQ-001 SHALL provide parameter P_CH, default 2, meaning number of parallel check channels (legal 1..4).
REQ-002 SHALL provide parameter P_DEPTH, default 4, meaning fault queue entries (power of two, legal 4..16, P_DEPTH >= 2*P_CH).
REQ-003 SHALL provide port iCLOCK  in  1  single clock; all logic is rising-edge.
REQ-004 SHALL provide port iRESET_SYNC  in  1  reset, synchronous and active-high.
REQ-005 SHALL provide port iFLUSH  in  1  discard the stage register and all queued faults.
REQ-006 SHALL provide port iPAGING_ENA  in  1  paging enabled; when 0, no channel faults.
REQ-007 SHALL provide port iVALID  in  P_CH  per-channel request valid.
REQ-008 SHALL provide port oBUSY  in/out: out  1  request stall; no channel is accepted while 1.
REQ-009 SHALL provide port iKERNEL_ACCESS  in  P_CH  per-channel kernel mode (1 = kernel).
REQ-010 SHALL provide port iWRITE_CHECK  in  P_CH  per-channel store access; enables the write-protect check.
REQ-011 SHALL provide port iMMU_FLAGS  in  14*P_CH  per-channel flags; channel n uses bits [14n+13:14n].
REQ-012 SHALL provide port oVALID  out  P_CH  per-channel result valid.
REQ-013 SHALL provide port oIRQ40, oIRQ41, oIRQ42  out  P_CH each  per-channel page fault / privilege error / invalid instruction.
REQ-014 SHALL provide port oFAULT_VALID  out  1  fault queue head valid.
REQ-015 SHALL provide port oFAULT_CH  out  2  channel index of the head entry.
REQ-016 SHALL provide port oFAULT_CODE  out  3  one-hot {IRQ42, IRQ41, IRQ40} of the head entry.
REQ-017 SHALL provide port iFAULT_ACK  in  1  pop the head entry.
REQ-018 SHALL provide port oFAULT_COUNT  out  5  number of occupied queue entries.
REQ-019 SHALL provide port oFAULT_OVF  out  1  sticky overflow flag.
REQ-020 SHALL provide port iOVF_CLEAR  in  1  clear oFAULT_OVF.

Function
REQ-021 SHALL accept channel n in a cycle when iVALID[n]=1, oBUSY=0, iFLUSH=0 and iRESET_SYNC=0.
REQ-022 SHALL classify each accepted channel with priority: flags[0]=0 -> IRQ40; else flags[3]=0 -> IRQ42; else user mode with flags[5:4]=0 -> IRQ41; else iWRITE_CHECK=1 with flags[2]=0 -> IRQ41; else no fault.
REQ-023 SHALL classify every channel as no fault when iPAGING_ENA=0, sampled in the acceptance cycle.
REQ-024 SHALL register results with 1-cycle latency: oVALID[n] and a one-hot or zero IRQ set appear in the cycle after acceptance and hold for exactly one cycle.
REQ-025 SHALL drive all three IRQ bits of a channel to 0 whenever its oVALID bit is 0.
REQ-026 SHALL push each faulting stage-register channel into the queue in the cycle after the result appears, in ascending channel order, with up to P_CH pushes per cycle.
REQ-027 SHALL compute pending as the number of faulting channels held in the stage register.
REQ-028 SHALL assert oBUSY combinationally when (P_DEPTH - oFAULT_COUNT - pending) < P_CH.
REQ-029 SHALL present the oldest entry on oFAULT_VALID, oFAULT_CH and oFAULT_CODE; these outputs are 0 when the queue is empty.
REQ-030 SHALL pop the head entry when iFAULT_ACK=1 and oFAULT_VALID=1; iFAULT_ACK is ignored when the queue is empty.
REQ-031 SHALL allow a pop and pushes in the same cycle; the count then changes by pushes minus 1.
REQ-032 SHALL keep the read and write pointers wrapping modulo P_DEPTH.
REQ-033 SHALL drop any push that would exceed P_DEPTH, set oFAULT_OVF, and keep existing entries intact.
REQ-034 SHALL give set precedence over clear when an overflow and iOVF_CLEAR=1 occur in the same cycle.
REQ-035 SHALL, on iFLUSH=1, clear the stage register, the pointers and the count in the next cycle, push nothing, and leave oFAULT_OVF unchanged.
REQ-036 SHALL give iFLUSH priority over acceptance, push and pop in the same cycle.

Reset
REQ-037 SHALL, on iRESET_SYNC=1 at a rising edge, set oVALID, all IRQ outputs, oFAULT_VALID, oFAULT_CH, oFAULT_CODE, oFAULT_COUNT and oFAULT_OVF to 0, and reset both pointers to 0.
REQ-038 SHALL deassert oBUSY after reset, because the queue is empty and pending is 0.
REQ-039 SHALL, when reset is asserted mid-operation, abandon in-flight stage results without pushing them.

Verification
REQ-040 SHALL cover: P_CH=2, paging=1; ch0 flags=14'h0000, ch1 flags=14'h0039 user -> next cycle oIRQ40=2'b01, oVALID=2'b11; following cycle queue head CH=0, CODE=3'b001, COUNT=1.
REQ-041 SHALL cover: user mode, flags=14'h0009 -> IRQ41; the same flags in kernel mode -> no fault; kernel mode, flags=14'h0019 with iWRITE_CHECK=1 -> IRQ41.
REQ-042 SHALL cover: iPAGING_ENA=0 with flags=0 on both channels -> no IRQ and COUNT stays 0.
REQ-043 SHALL cover: P_DEPTH=4, both channels faulting every cycle and no ACK -> oBUSY=1 once COUNT+pending exceeds 2, COUNT tops at 4, oFAULT_OVF stays 0; then one ACK per cycle drains in FIFO order.
REQ-044 SHALL cover: forcing overflow by holding ACK low while bypassing oBUSY in the bench -> oFAULT_OVF=1; iOVF_CLEAR then clears it; an overflow coinciding with iOVF_CLEAR leaves it 1.
REQ-045 SHALL cover: iFLUSH with COUNT=3 and simultaneous ACK and new faults -> next cycle COUNT=0, oVALID=0, oFAULT_VALID=0.
